cic_conv_sequencer: RTL and testbench

Conversion sequencer for the differential VCO-ADC CIC datapath. Holds the CIC pair in reset while idle and releases it on a START request. Discards the CIC pipeline-fill period, then captures 2^NSAMP_LOG2 decimated samples of the signed differential CIC output and accumulates them. Returns one conversion result with a DONE pulse. Sits between the digital top-level control and the differential CIC instance; drives that instance's RES and ENABLE.

---
 rtl/cic_conv_sequencer.sv | 159 +++++++++++++++
 tb/tb_cic_conv_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_conv_sequencer.sv
// Conversion sequencer for the differential VCO-ADC CIC pair: reset hold, pipeline-fill discard,
// decimated accumulate, DONE pulse. Optional macro CIC_SEQ_AVG_EN returns the mean instead of the sum.
module cic_conv_sequencer #(
    parameter int BW         = 5,
    parameter int SETTLE_CYC = 8,
    parameter int DEC_RATE   = 4,
    parameter int NSAMP_LOG2 = 3
) (
    input  logic                       CLK,
    input  logic                       RES,
    input  logic                       START,
    input  logic                       ABORT,
    input  logic [BW:0]                CIC_OUT,
    output logic                       CIC_RES,
    output logic                       CIC_EN,
    output logic                       BUSY,
    output logic                       DONE,
    output logic [BW+NSAMP_LOG2:0]     RESULT
);
    localparam int AW = BW + 1 + NSAMP_LOG2;
    localparam int SW = NSAMP_LOG2 + 1;
    localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [7:0]    DEC_LAST    = 8'(DEC_RATE - 1);
    localparam logic [SW-1:0] SAMP_LAST   = SW'((1 << NSAMP_LOG2) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SETTLE,
        S_ACQ,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [7:0]           dec_q, dec_d;
    logic [SW-1:0]        samp_q, samp_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [AW-1:0]        result_q, result_d;
    logic                 cic_res_q, cic_res_d;
    logic                 cic_en_q, cic_en_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic signed [AW-1:0] sample_ext;
    logic signed [AW-1:0] acc_sum;
    logic signed [AW-1:0] result_val;

    always_comb begin
        sample_ext = AW'($signed(CIC_OUT));
        acc_sum    = acc_q + sample_ext;
`ifdef CIC_SEQ_AVG_EN
        result_val = acc_sum >>> NSAMP_LOG2;
`else
        result_val = acc_sum;
`endif
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dec_d    = dec_q;
        samp_d   = samp_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                dec_d  = '0;
                samp_d = '0;
                if (START) begin
                    state_d = S_CLEAR;
                    acc_d   = '0;
                end
            end
            S_CLEAR: begin
                if (ABORT) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 8'd1) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_SETTLE: begin
                if (ABORT) begin
                    state_d = S_IDLE;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = S_ACQ;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_ACQ: begin
                // ABORT wins even against the final sample, so it is tested first.
                if (ABORT) begin
                    state_d = S_IDLE;
                end else if (dec_q == DEC_LAST) begin
                    dec_d  = '0;
                    acc_d  = acc_sum;
                    samp_d = samp_q + 1'b1;
                    if (samp_q == SAMP_LAST) begin
                        state_d  = S_DONE;
                        result_d = result_val;
                    end
                end else begin
                    dec_d = dec_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they are registered with it.
        cic_en_d  = (state_d == S_SETTLE) || (state_d == S_ACQ);
        cic_res_d = !cic_en_d;
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge CLK) begin
        if (!RES) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dec_q     <= '0;
            samp_q    <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            cic_res_q <= 1'b1;
            cic_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dec_q     <= dec_d;
            samp_q    <= samp_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            cic_res_q <= cic_res_d;
            cic_en_q  <= cic_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign CIC_RES = cic_res_q;
    assign CIC_EN  = cic_en_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign RESULT  = result_q;

endmodule

// File: tb/tb_cic_conv_sequencer.sv
// Self-checking bench for cic_conv_sequencer at SETTLE_CYC=4, DEC_RATE=2, NSAMP_LOG2=2, BW=5.
// Expected results follow the CIC_SEQ_AVG_EN setting of the build.
module tb_cic_conv_sequencer;
    localparam int BW  = 5;
    localparam int S   = 4;
    localparam int D   = 2;
    localparam int NL  = 2;
    localparam int N   = 1 << NL;
    localparam int AW  = BW + 1 + NL;
    localparam int LAT = S + 2 + N * D;
    localparam int PER = S + 4 + N * D;

    logic          CLK = 1'b0;
    logic          RES = 1'b0;
    logic          START = 1'b0;
    logic          ABORT = 1'b0;
    logic [BW:0]   CIC_OUT = '0;
    logic          CIC_RES;
    logic          CIC_EN;
    logic          BUSY;
    logic          DONE;
    logic [AW-1:0] RESULT;

    int tests_run = 0;
    int tests_failed = 0;
    logic [AW-1:0] model_result = '0;

    cic_conv_sequencer #(
        .BW(BW), .SETTLE_CYC(S), .DEC_RATE(D), .NSAMP_LOG2(NL)
    ) dut (
        .CLK(CLK), .RES(RES), .START(START), .ABORT(ABORT), .CIC_OUT(CIC_OUT),
        .CIC_RES(CIC_RES), .CIC_EN(CIC_EN), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic int pat_val(input int pat, input int j);
        case (pat)
            0:       return 5;
            1:       return -3;
            2:       return (j % 2 == 0) ? 31 : -32;
            default: return int'($urandom_range(0, 63)) - 32;
        endcase
    endfunction

    function automatic logic [AW-1:0] expected_result(input int sum);
        int r;
`ifdef CIC_SEQ_AVG_EN
        r = sum >>> NL;
`else
        r = sum;
`endif
        return AW'(r);
    endfunction

    // One conversion from IDLE. abort_c >= 0 raises ABORT during the cycle after edge abort_c.
    task automatic run_conv(input string name, input int pat, input int abort_c, input bit abort_idle);
        int sum;
        int j;
        int v;
        int e;
        bit aborted;
        logic [AW-1:0] exp_res;
        sum = 0;
        aborted = 0;
        START = 1'b1;
        ABORT = abort_idle;
        CIC_OUT = 6'($urandom);
        tick();
        START = 1'b0;
        ABORT = 1'b0;
        tests_run++;
        if (BUSY !== 1'b1 || CIC_RES !== 1'b1 || CIC_EN !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s start: busy=%0b res=%0b en=%0b want 1 1 0", name, BUSY, CIC_RES, CIC_EN);
        end
        for (int c = 0; c < LAT; c++) begin
            j = c - (2 + S);
            if (j >= 0) begin
                v = pat_val(pat, j);
                CIC_OUT = 6'(v);
                if (j % D == D - 1) sum += v;
            end else begin
                CIC_OUT = 6'($urandom);
            end
            ABORT = (c == abort_c);
            tick();
            ABORT = 1'b0;
            e = c + 1;
            if (c == abort_c) begin
                tests_run++;
                if (BUSY !== 1'b0 || DONE !== 1'b0 || RESULT !== model_result) begin
                    tests_failed++;
                    $display("FAIL %s abort: busy=%0b done=%0b result=%0d want 0 0 %0d",
                             name, BUSY, DONE, RESULT, model_result);
                end
                aborted = 1;
                break;
            end
            tests_run++;
            if (CIC_EN !== (e >= 2 && e < LAT) || CIC_RES !== !(e >= 2 && e < LAT)) begin
                tests_failed++;
                $display("FAIL %s cic_en edge %0d: en=%0b res=%0b want en=%0b", name, e, CIC_EN, CIC_RES,
                         (e >= 2 && e < LAT));
            end
            tests_run++;
            if (DONE !== (e == LAT)) begin
                tests_failed++;
                $display("FAIL %s done edge %0d: got %0b want %0b", name, e, DONE, (e == LAT));
            end
        end
        if (!aborted) begin
            exp_res = expected_result(sum);
            model_result = exp_res;
            tests_run++;
            if (RESULT !== exp_res) begin
                tests_failed++;
                $display("FAIL %s result: got %0d (0x%h) want %0d (0x%h)", name, $signed(RESULT), RESULT,
                         $signed(exp_res), exp_res);
            end
            tick();
            tests_run++;
            if (DONE !== 1'b0 || BUSY !== 1'b0 || CIC_RES !== 1'b1 || RESULT !== exp_res) begin
                tests_failed++;
                $display("FAIL %s after_done: done=%0b busy=%0b res=%0b result=%0d want 0 0 1 %0d",
                         name, DONE, BUSY, CIC_RES, RESULT, exp_res);
            end
        end
        tick();
    endtask

    task automatic test_reset();
        RES = 1'b0;
        START = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (CIC_RES !== 1'b1 || CIC_EN !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0 || RESULT !== '0) begin
                tests_failed++;
                $display("FAIL reset cycle %0d: res=%0b en=%0b busy=%0b done=%0b result=%0d want 1 0 0 0 0",
                         i, CIC_RES, CIC_EN, BUSY, DONE, RESULT);
            end
        end
        START = 1'b0;
        RES = 1'b1;
        tick();
        tests_run++;
        if (BUSY !== 1'b0 || CIC_RES !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release: busy=%0b res=%0b want 0 1", BUSY, CIC_RES);
        end
        model_result = '0;
    endtask

    task automatic test_nominal();
        run_conv("nominal", 0, -1, 0);
    endtask

    task automatic test_negative();
        run_conv("negative", 1, -1, 0);
    endtask

    task automatic test_decimation();
        run_conv("decimation", 2, -1, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) run_conv("random", 3, -1, 0);
    endtask

    task automatic test_abort();
        run_conv("abort_prep", 0, -1, 0);
        run_conv("abort_acq", 3, 2 + S + 2 * D + D - 1, 0);
        run_conv("abort_after", 0, -1, 0);
        run_conv("abort_clear", 3, 0, 0);
        run_conv("abort_settle", 3, 2 + $urandom_range(0, S - 1), 0);
        run_conv("abort_final", 3, LAT - 1, 0);
        run_conv("abort_idle", 1, -1, 1);
    endtask

    task automatic test_back_to_back();
        int waited;
        START = 1'b1;
        CIC_OUT = 6'd5;
        tick();
        for (int e = 1; e <= 3 * PER + 2; e++) begin
            tick();
            tests_run++;
            if (DONE !== (e >= LAT && (e - LAT) % PER == 0)) begin
                tests_failed++;
                $display("FAIL back_to_back done edge %0d: got %0b want %0b", e, DONE,
                         (e >= LAT && (e - LAT) % PER == 0));
            end
        end
        START = 1'b0;
        waited = 0;
        while (BUSY === 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        tests_run++;
        if (BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL back_to_back drain: busy=%0b want 0", BUSY);
        end
        model_result = expected_result(5 * N);
        tests_run++;
        if (RESULT !== model_result) begin
            tests_failed++;
            $display("FAIL back_to_back result: got %0d want %0d", RESULT, model_result);
        end
    endtask

    task automatic test_reset_mid();
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < S + 3; i++) tick();
        RES = 1'b0;
        tick();
        RES = 1'b1;
        tests_run++;
        if (BUSY !== 1'b0 || CIC_EN !== 1'b0 || DONE !== 1'b0 || RESULT !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid: busy=%0b en=%0b done=%0b result=%0d want 0 0 0 0", BUSY, CIC_EN, DONE, RESULT);
        end
        model_result = '0;
        for (int i = 0; i < LAT + 2; i++) begin
            tick();
            tests_run++;
            if (DONE !== 1'b0 || BUSY !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_mid idle %0d: done=%0b busy=%0b want 0 0", i, DONE, BUSY);
            end
        end
        run_conv("post_reset", 3, -1, 0);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_negative();
        test_decimation();
        test_random();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
